// File: rtl/intdiv_restoring.sv
// intdiv_restoring
// ----------------
// Sequential radix-2 restoring unsigned divider: Q = A / B, R = A mod B.
// One quotient bit is produced per cycle, MSB first. There is one extra
// cycle that transfers the result into the output registers. As a result,
// out_valid rises LAT = W_A+1 edges after the accept edge, whatever the
// operand values are.
//
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   A, B         - dividend (W_A bits) / divisor (W_B bits), sampled on accept
//   in_valid     - operands valid
//   in_ready     - high in IDLE only; accept = in_valid & in_ready
//   Q, R         - quotient (W_A bits) / remainder (W_B bits)
//   div_by_zero  - the sampled B was zero (Q = all ones, R = A[W_B-1:0])
//   out_valid    - Q/R/div_by_zero valid; held until out_ready
//   out_ready    - consumer accepts the result
module intdiv_restoring #(
  parameter int W_A = 128,
  parameter int W_B = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W_A-1:0] A,
  input  logic [W_B-1:0] B,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W_A-1:0] Q,
  output logic [W_B-1:0] R,
  output logic           div_by_zero,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int LAT = W_A + 1;
  localparam int CW  = $clog2(W_A + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W_A-1:0] quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [W_B-1:0] rem_q, rem_d;   // partial remainder (always < divisor)
  logic [W_B-1:0] div_q, div_d;
  logic           dz_q, dz_d;
  logic [W_A-1:0] q_out_q, q_out_d;
  logic [W_B-1:0] r_out_q, r_out_d;
  logic           dzo_q, dzo_d;

  // The shifted partial remainder carries the guard bit. Because rem < divisor
  // holds, the shifted value stays below 2*divisor. The subtract therefore
  // never wraps when it is taken, and the result fits back in W_B bits.
  logic [W_B:0]   shifted;
  logic [W_B:0]   trial;
  logic           take;

  always_comb begin
    shifted = {rem_q, quo_q[W_A-1]};
    trial   = shifted - {1'b0, div_q};
    take    = (shifted >= {1'b0, div_q});
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    dz_d      = dz_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    dzo_d     = dzo_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          quo_d   = A;
          div_d   = B;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (B == '0);
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (cnt_q == CW'(LAT - 1)) begin
          // All W_A bits are resolved. Publish the result on the edge that
          // enters DONE. With B == 0 every trial is taken, so the remainder
          // already holds A[W_B-1:0]. The quotient is forced for clarity.
          q_out_d = dz_q ? '1 : quo_q;
          r_out_d = rem_q;
          dzo_d   = dz_q;
          state_d = S_DONE;
        end else begin
          rem_d = take ? trial[W_B-1:0] : shifted[W_B-1:0];
          quo_d = {quo_q[W_A-2:0], take};
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      dz_q    <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dzo_q   <= dzo_d;
    end
  end

  always_comb begin
    Q           = q_out_q;
    R           = r_out_q;
    div_by_zero = dzo_q;
  end

endmodule

// File: tb/tb_intdiv_restoring.sv
module tb_intdiv_restoring;

  localparam int W_A = 128;
  localparam int W_B = 64;
  localparam int LAT = W_A + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W_A-1:0] A = '0;
  logic [W_B-1:0] B = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W_A-1:0] Q;
  logic [W_B-1:0] R;
  logic           div_by_zero;
  logic           out_valid;
  logic           out_ready = 1'b1;

  intdiv_restoring #(.W_A(W_A), .W_B(W_B)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
    .in_ready(in_ready), .Q(Q), .R(R), .div_by_zero(div_by_zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W_A-1:0] q;
    logic [W_B-1:0] r;
    logic           dz;
    longint         acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   lat_done = 1'b0;

  task automatic chk(input string name, input logic [W_A-1:0] act,
                     input logic [W_A-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer division on the full operand widths.
  function automatic exp_t model(input logic [W_A-1:0] a, input logic [W_B-1:0] b);
    exp_t e;
    logic [W_A-1:0] bw;
    logic [W_A-1:0] rw;
    bw = {{(W_A-W_B){1'b0}}, b};
    if (b == 0) begin
      e.q  = '1;
      e.r  = a[W_B-1:0];
      e.dz = 1'b1;
    end else begin
      rw   = a % bw;
      e.q  = a / bw;
      e.r  = rw[W_B-1:0];
      e.dz = 1'b0;
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic [W_A-1:0] a, input logic [W_B-1:0] b);
    exp_t e;
    int unsigned guard;
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    e = model(a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    A = {$urandom, $urandom, $urandom, $urandom};
    B = {$urandom, $urandom};
  endtask

  task automatic wait_empty();
    int unsigned guard;
    guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
    end
  endtask

  // Monitor: latency is checked at the first out_valid cycle. Values are
  // checked on the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_result: Q got %h expected none", Q);
      end else begin
        if (!lat_done) begin
          chk("latency", W_A'(cyc - sb[0].acc), W_A'(LAT));
          lat_done = 1'b1;
        end
        if (out_ready) begin
          exp_t e;
          e = sb.pop_front();
          chk("Q", Q, e.q);
          chk("R", W_A'(R), W_A'(e.r));
          chk("div_by_zero", W_A'(div_by_zero), W_A'(e.dz));
          lat_done = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [W_A-1:0] q_hold;
    logic [W_B-1:0] r_hold;
    logic [W_A-1:0] ra;
    logic [W_B-1:0] rb;
    int unsigned guard;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", W_A'(in_ready), W_A'(1));
    chk("rst_out_valid", W_A'(out_valid), W_A'(0));
    chk("rst_Q", Q, '0);
    chk("rst_R", W_A'(R), '0);
    chk("rst_dz", W_A'(div_by_zero), '0);
    rst = 1'b0;

    // Directed cases.
    send(128'hFFFFFFFFFFFFFFFE0000000000000001, 64'hFFFFFFFFFFFFFFFF);
    send(128'd100, 64'd7);
    send(128'd6, 64'd7);
    send('1, 64'd1);
    send(128'h1234_0000_0000_0000_0000_0000_DEAD_BEEF, 64'd0);
    send(128'd0, 64'd5);
    wait_empty();

    // Back-pressure: the result is held, and new requests are ignored.
    out_ready = 1'b0;
    send(128'd1000, 64'd33);
    guard = 0;
    while (!out_valid && guard < LAT + 10) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_out_valid", W_A'(out_valid), W_A'(1));
    q_hold = Q; r_hold = R;
    A = 128'd5; B = 64'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_Q_stable", Q, q_hold);
      chk("bp_R_stable", W_A'(R), W_A'(r_hold));
      chk("bp_in_ready", W_A'(in_ready), '0);
      chk("bp_valid_held", W_A'(out_valid), W_A'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_out_valid", W_A'(out_valid), '0);
    chk("bp_after_in_ready", W_A'(in_ready), W_A'(1));
    repeat (3) @(negedge clk);

    // Random back-to-back operations.
    for (int n = 0; n < 200; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = 64'($urandom_range(1, 255));
        1:       rb = {32'd0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      if (rb == 0) rb = 64'd1;
      if ($urandom_range(0, 7) == 0) ra = ra >> $urandom_range(0, 127);
      send(ra, rb);
    end
    wait_empty();

    // Reset during iteration 40: the operation is discarded.
    send(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 64'd12345);
    repeat (39) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    lat_done = 1'b0;
    chk("abort_out_valid", W_A'(out_valid), '0);
    chk("abort_in_ready", W_A'(in_ready), W_A'(1));
    chk("abort_Q", Q, '0);
    chk("abort_R", W_A'(R), '0);
    rst = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    send(128'd100, 64'd7);
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: time got %0t expected less", $time);
    $fatal(1);
  end

endmodule
